// File: rtl/pipeline_if_pkg.sv
// rtl/pipeline_if_pkg.sv - shared constants, state encoding and entry layout for the fetch stage
package pipeline_if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_WIDTH       = 32;

  typedef enum logic [1:0] {
    IF_ST_IDLE = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_DROP = 2'd2
  } if_state_t;

  // One buffered fetch: the word together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipeline_if_fetch_fifo.sv
// rtl/pipeline_if_fetch_fifo.sv - small synchronous FIFO with flush, registered head
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_if.sv
// rtl/pipeline_if.sv - instruction fetch stage: PC, one-outstanding memory FSM, fetch buffer
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_ready,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_t    state;
  if_state_t    next_state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         issue;
  logic         push;
  logic         pop;
  logic         space;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  fetch_entry_t last_entry;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty;
  logic         fifo_full_unused;

  // Requests are only issued from IDLE, so nothing is outstanding when space is checked.
  assign space = (fifo_count < CW'(FIFO_DEPTH));

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    push       = 1'b0;
    if (redirect) begin
      next_state = (state != IF_ST_IDLE && !imem_ack) ? IF_ST_DROP : IF_ST_IDLE;
    end else begin
      case (state)
        IF_ST_IDLE: begin
          if (space) begin
            issue      = 1'b1;
            next_state = IF_ST_WAIT;
          end
        end
        IF_ST_WAIT: begin
          if (imem_ack) begin
            push       = 1'b1;
            next_state = IF_ST_IDLE;
          end
        end
        IF_ST_DROP: begin
          if (imem_ack) begin
            next_state = IF_ST_IDLE;
          end
        end
        default: next_state = IF_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IF_ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= next_state;
      if (redirect) begin
        pc <= word_align(redirect_pc);
      end else if (issue) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
    end
  end

  // The strobe is combinational from IDLE; hold it off while reset is asserted.
  assign imem_req  = issue && !rst;
  assign imem_addr = pc;

  assign push_entry = '{pc: req_pc, word: imem_data};
  assign pop        = inst_valid && id_ready;

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head_entry),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full_unused)
  );

  // Remember what decode last saw so inst/inst_pc hold steady while the buffer is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_entry <= '0;
    end else if (!fifo_empty) begin
      last_entry <= head_entry;
    end
  end

  assign inst_valid = !fifo_empty;
  assign inst       = fifo_empty ? last_entry.word : head_entry.word;
  assign inst_pc    = fifo_empty ? last_entry.pc   : head_entry.pc;

endmodule

// File: tb/tb_pipeline_if.sv
// tb/tb_pipeline_if.sv - self-checking bench for the fetch stage with a memory and stream model
module tb_pipeline_if;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  // memory model and expected instruction stream
  logic [31:0] seed;
  bit          pend, live;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          held;
  logic [31:0] exp_fetch, exp_pop, last_pc, last_inst;
  int          lat_cfg, slow_lat;
  bit          slow_on;
  logic [31:0] slow_addr;
  bit          rdy_rand, rdy_cfg;
  bit          obs_req, obs_pop, obs_ack, obs_valid;
  logic [31:0] obs_addr, obs_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check, then advance to the next falling edge.
  task automatic tick(input bit redir, input logic [31:0] rpc, input bit pulse);
    bit ack_now, busy, exp_req, accepted;
    int held_start;
    ack_now = 1'b0;
    busy    = pend;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        ack_now = 1'b1;
        pend    = 1'b0;
      end
    end
    accepted = ack_now && live && !redir;
    if (ack_now) live = 1'b0;
    id_ready    = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_cfg;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = ack_now;
    imem_data   = ack_now ? mem_word(pend_addr) : $urandom();
    obs_ack     = ack_now;
    if (pulse) begin
      rst = 1'b1;
      #1;
      total++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL async_rst_ctrl: got valid=%b req=%b want 0 0", inst_valid, imem_req);
      if (inst_valid !== 1'b0 || imem_req !== 1'b0) bad++;
      total++;
      if (inst !== 32'h0 || inst_pc !== 32'h0) begin
        bad++;
        $display("FAIL async_rst_data: got inst=%h pc=%h want 0 0", inst, inst_pc);
      end
      rst       = 1'b0;
      held      = 0;
      exp_fetch = RST_PC;
      exp_pop   = RST_PC;
      last_pc   = 32'h0;
      last_inst = 32'h0;
      busy      = 1'b0;
      accepted  = 1'b0;
      live      = 1'b0;
      pend      = 1'b0;
    end
    #1;
    held_start = held;
    obs_req    = (imem_req === 1'b1);
    obs_addr   = imem_addr;
    obs_valid  = (inst_valid === 1'b1);
    obs_pop    = 1'b0;
    exp_req    = !busy && (held_start < 2) && !redir;
    total++;
    if (imem_req !== exp_req) begin
      bad++;
      $display("FAIL req_strobe: got %b want %b at %0t", imem_req, exp_req, $time);
    end
    total++;
    if (inst_valid !== (held_start > 0)) begin
      bad++;
      $display("FAIL inst_valid: got %b want %b at %0t", inst_valid, held_start > 0, $time);
    end
    if (inst_valid === 1'b1) begin
      total++;
      if (inst_pc !== exp_pop || inst !== mem_word(exp_pop)) begin
        bad++;
        $display("FAIL head: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, exp_pop, mem_word(exp_pop));
      end
      last_pc   = exp_pop;
      last_inst = mem_word(exp_pop);
      if (id_ready) begin
        obs_pop    = 1'b1;
        obs_pop_pc = exp_pop;
        exp_pop    = exp_pop + 32'd4;
        held--;
      end
    end else begin
      total++;
      if (inst_pc !== last_pc || inst !== last_inst) begin
        bad++;
        $display("FAIL hold: got pc=%h inst=%h want pc=%h inst=%h", inst_pc, inst, last_pc, last_inst);
      end
    end
    if (imem_req === 1'b1) begin
      total++;
      if (imem_addr !== exp_fetch) begin
        bad++;
        $display("FAIL req_addr: got %h want %h", imem_addr, exp_fetch);
      end
      pend      = 1'b1;
      live      = 1'b1;
      pend_addr = exp_fetch;
      pend_cnt  = (slow_on && exp_fetch == slow_addr) ? slow_lat
                : (lat_cfg > 0 ? lat_cfg : int'($urandom_range(1, 3)));
      exp_fetch = exp_fetch + 32'd4;
    end
    if (accepted) held++;
    if (redir) begin
      held      = 0;
      exp_pop   = {rpc[31:2], 2'b00};
      exp_fetch = {rpc[31:2], 2'b00};
      live      = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_data = 32'h0; id_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0; live = 1'b0; held = 0;
    exp_fetch = RST_PC; exp_pop = RST_PC; last_pc = 32'h0; last_inst = 32'h0;
    rdy_rand = 1'b0; rdy_cfg = 1'b1; lat_cfg = 1; slow_on = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0)    begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
    total++; if (inst_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    total++; if (inst !== 32'h0)       begin bad++; $display("FAIL rst_inst: got %h want 0", inst); end
    total++; if (inst_pc !== 32'h0)    begin bad++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
    apply_reset();
  endtask

  task automatic test_stream();
    logic [31:0] addrs[$];
    int ticks[$];
    int pops;
    apply_reset();
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req) begin addrs.push_back(obs_addr); ticks.push_back(i); end
      if (obs_pop) pops++;
    end
    total++;
    if (addrs.size() < 4) begin
      bad++; $display("FAIL stream_count: got %0d want >=4", addrs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (addrs[k] !== 32'(4 * k)) begin bad++; $display("FAIL stream_addr: got %h want %h", addrs[k], 32'(4 * k)); end
        total++;
        if (ticks[k] != 2 * k) begin bad++; $display("FAIL stream_gap: got %0d want %0d", ticks[k], 2 * k); end
      end
    end
    total++;
    if (pops < 4) begin bad++; $display("FAIL stream_pops: got %0d want >=4", pops); end
  endtask

  task automatic test_stall();
    logic [31:0] addrs[$];
    logic [31:0] pops[$];
    logic [31:0] next_addr;
    bit got_req;
    apply_reset();
    rdy_cfg = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req) addrs.push_back(obs_addr);
    end
    total++;
    if (addrs.size() != 2) begin
      bad++; $display("FAIL stall_count: got %0d want 2", addrs.size());
    end else begin
      total++;
      if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4) begin
        bad++; $display("FAIL stall_addr: got %h,%h want 0,4", addrs[0], addrs[1]);
      end
    end
    rdy_cfg = 1'b1;
    got_req = 1'b0;
    next_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_pop) pops.push_back(obs_pop_pc);
      if (obs_req && !got_req) begin got_req = 1'b1; next_addr = obs_addr; end
    end
    total++;
    if (pops.size() < 2 || pops[0] !== 32'h0 || pops[1] !== 32'h4) begin
      bad++; $display("FAIL stall_pops: got %0d pops want 0,4 first", pops.size());
    end
    total++;
    if (!got_req || next_addr !== 32'h8) begin
      bad++; $display("FAIL stall_resume: got %h want 00000008", next_addr);
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found;
    int wait_ticks;
    apply_reset();
    slow_on = 1'b1; slow_addr = 32'h8; slow_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req && obs_addr === 32'h8) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL redir_setup: got no request to 8 want one"); end
    tick(1'b1, 32'h0000_1002, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    total++;
    if (obs_valid) begin bad++; $display("FAIL redir_valid: got 1 want 0"); end
    wait_ticks = 1;
    while (!obs_req && wait_ticks < 10) begin
      tick(1'b0, 32'h0, 1'b0);
      wait_ticks++;
    end
    total++;
    if (!obs_req || obs_addr !== 32'h0000_1000 || wait_ticks != 3) begin
      bad++; $display("FAIL redir_next: got addr=%h after %0d want 00001000 after 3", obs_addr, wait_ticks);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_pop) found = 1'b1;
    end
    total++;
    if (!found || obs_pop_pc !== 32'h0000_1000) begin
      bad++; $display("FAIL redir_first_pc: got %h want 00001000", obs_pop_pc);
    end
    slow_on = 1'b0;
  endtask

  task automatic test_redirect_ack();
    bit found;
    apply_reset();
    slow_on = 1'b1; slow_addr = 32'h8; slow_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req && obs_addr === 32'h8) found = 1'b1;
    end
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'h0000_2000, 1'b0);
    total++;
    if (!found || !obs_ack) begin bad++; $display("FAIL ackredir_setup: got ack=%b want 1", obs_ack); end
    tick(1'b0, 32'h0, 1'b0);
    total++;
    if (!obs_req || obs_addr !== 32'h0000_2000) begin
      bad++; $display("FAIL ackredir_next: got req=%b addr=%h want 1 00002000", obs_req, obs_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_pop) found = 1'b1;
    end
    total++;
    if (!found || obs_pop_pc !== 32'h0000_2000) begin
      bad++; $display("FAIL ackredir_pc: got %h want 00002000", obs_pop_pc);
    end
    slow_on = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pops[$];
    apply_reset();
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b1, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req) addrs.push_back(obs_addr);
      if (obs_pop) pops.push_back(obs_pop_pc);
    end
    total++;
    if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got %0d requests want FFFFFFFC then 00000000", addrs.size());
    end
    total++;
    if (pops.size() < 2 || pops[0] !== 32'hFFFF_FFFC || pops[1] !== 32'h0) begin
      bad++; $display("FAIL wrap_pc: got %0d pops want FFFFFFFC then 00000000", pops.size());
    end
  endtask

  task automatic test_async_reset();
    bit found;
    apply_reset();
    rdy_cfg = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_req && obs_addr === 32'h4) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL arst_setup: got no request to 4 want one"); end
    tick(1'b0, 32'h0, 1'b1);
    total++;
    if (!obs_req || obs_addr !== RST_PC) begin
      bad++; $display("FAIL arst_restart: got req=%b addr=%h want 1 %h", obs_req, obs_addr, RST_PC);
    end
    rdy_cfg = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (obs_pop) found = 1'b1;
    end
    total++;
    if (!found || obs_pop_pc !== RST_PC) begin
      bad++; $display("FAIL arst_first_pc: got %h want %h", obs_pop_pc, RST_PC);
    end
  endtask

  task automatic test_random();
    int pops;
    apply_reset();
    rdy_rand = 1'b1;
    lat_cfg  = 0;
    pops     = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) tick(1'b1, $urandom(), 1'b0);
      else                             tick(1'b0, 32'h0, 1'b0);
      if (obs_pop) pops++;
    end
    total++;
    if (pops < 20) begin bad++; $display("FAIL random_progress: got %0d pops want >=20", pops); end
  endtask

  initial begin
    seed = $urandom();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_data = 32'h0; id_ready = 1'b0;
    pend = 1'b0; live = 1'b0; held = 0; lat_cfg = 1; slow_on = 1'b0; slow_addr = 32'h0; slow_lat = 1;
    rdy_rand = 1'b0; rdy_cfg = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
